// File: rtl/equeue_rs.sv
`default_nettype none
// ============================================================================
// Module   : equeue_rs
// Brief    : Compacting reservation station with CDB snoop; KIND selects the
//            INT / DIV (oldest-ready-first) or LS (in-order head) issue rules.
// Revision : 1.0
// ============================================================================
module equeue_rs #(
    parameter int KIND  = 0,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dispatch_en,
    output logic        dispatch_ready,
    input  logic [5:0]  dispatch_opcode,
    input  logic [5:0]  dispatch_rdtag,
    input  logic [5:0]  dispatch_rstag,
    input  logic [5:0]  dispatch_rttag,
    input  logic [31:0] dispatch_rsdata,
    input  logic [31:0] dispatch_rtdata,
    input  logic        dispatch_rsvalid,
    input  logic        dispatch_rtvalid,
    input  logic [15:0] dispatch_offset,
    input  logic [5:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    input  logic        cdb_valid,
    output logic        issue_ready,
    output logic [5:0]  issue_opcode,
    output logic [5:0]  issue_rdtag,
    output logic [5:0]  issue_rttag,
    output logic [31:0] issue_rsdata,
    output logic [31:0] issue_rtdata,
    output logic [31:0] issue_addr,
    output logic [31:0] issue_data,
    input  logic        issue_done
);

    localparam int              c_CW    = $clog2(DEPTH + 1);
    localparam int              c_IW    = $clog2(DEPTH);
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);
    localparam bit              c_IS_LS = (KIND == 2);

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  rdtag;
        logic [5:0]  rstag;
        logic [5:0]  rttag;
        logic [31:0] rsdata;
        logic [31:0] rtdata;
        logic        rsvalid;
        logic        rtvalid;
        logic [15:0] offset;
    } entry_t;

    entry_t            r_ent [DEPTH];
    logic [c_CW-1:0]   r_count;

    logic [DEPTH-1:0]  w_rdy;
    logic [c_IW-1:0]   w_sel;
    logic              w_sel_vld;
    entry_t            w_sel_ent;
    logic              w_pop;
    logic              w_push;
    logic [c_CW-1:0]   w_wr_idx;
    logic [c_CW-1:0]   w_count_nxt;
    entry_t            w_incoming;
    entry_t            w_snp [DEPTH+1];
    entry_t            w_nxt [DEPTH];

    function automatic entry_t f_snoop(input entry_t e, input logic v,
                                       input logic [5:0] t, input logic [31:0] d);
        entry_t r;
        r = e;
        if (v && r.valid && !r.rsvalid && (r.rstag == t)) begin
            r.rsdata  = d;
            r.rsvalid = 1'b1;
        end
        if (v && r.valid && !r.rtvalid && (r.rttag == t)) begin
            r.rtdata  = d;
            r.rtvalid = 1'b1;
        end
        return r;
    endfunction

    // A load's rt field names its destination, so only rs gates it.
    function automatic logic f_ready(input entry_t e);
        if (c_IS_LS && !e.opcode[0]) begin
            return e.valid && e.rsvalid;
        end
        return e.valid && e.rsvalid && e.rtvalid;
    endfunction

    for (genvar g = 0; g < DEPTH; g++) begin : g_rdy
        assign w_rdy[g] = f_ready(r_ent[g]);
    end

    if (c_IS_LS) begin : g_sel_head
        assign w_sel     = '0;
        assign w_sel_vld = w_rdy[0];
    end else begin : g_sel_oldest
        always_comb begin
            w_sel     = '0;
            w_sel_vld = 1'b0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (w_rdy[i]) begin
                    w_sel     = c_IW'(i);
                    w_sel_vld = 1'b1;
                end
            end
        end
    end

    assign w_sel_ent      = r_ent[w_sel];
    assign dispatch_ready = (r_count < c_DEPTH);

    always_comb begin
        issue_ready  = 1'b0;
        issue_opcode = '0;
        issue_rdtag  = '0;
        issue_rttag  = '0;
        issue_rsdata = '0;
        issue_rtdata = '0;
        issue_addr   = '0;
        issue_data   = '0;
        if (w_sel_vld) begin
            issue_ready  = 1'b1;
            issue_opcode = w_sel_ent.opcode;
            issue_rdtag  = w_sel_ent.rdtag;
            issue_rttag  = w_sel_ent.rttag;
            issue_rsdata = w_sel_ent.rsdata;
            issue_rtdata = w_sel_ent.rtdata;
            if (c_IS_LS) begin
                issue_addr = w_sel_ent.rsdata
                           + {{16{w_sel_ent.offset[15]}}, w_sel_ent.offset};
                issue_data = w_sel_ent.rtdata;
            end
        end
    end

    // Snoop, remove the popped slot by shifting younger entries down, then
    // append the dispatched entry at the first free slot of the result.
    always_comb begin
        w_pop  = issue_done && w_sel_vld;
        w_push = dispatch_en && (r_count < c_DEPTH);

        w_incoming.valid   = 1'b1;
        w_incoming.opcode  = dispatch_opcode;
        w_incoming.rdtag   = dispatch_rdtag;
        w_incoming.rstag   = dispatch_rstag;
        w_incoming.rttag   = dispatch_rttag;
        w_incoming.rsdata  = dispatch_rsdata;
        w_incoming.rtdata  = dispatch_rtdata;
        w_incoming.rsvalid = dispatch_rsvalid;
        w_incoming.rtvalid = dispatch_rtvalid;
        w_incoming.offset  = dispatch_offset;
        w_incoming         = f_snoop(w_incoming, cdb_valid, cdb_tag, cdb_data);

        for (int i = 0; i < DEPTH; i++) begin
            w_snp[i] = f_snoop(r_ent[i], cdb_valid, cdb_tag, cdb_data);
        end
        w_snp[DEPTH] = '0;

        w_wr_idx = r_count - {{(c_CW-1){1'b0}}, w_pop};
        for (int i = 0; i < DEPTH; i++) begin
            w_nxt[i] = (w_pop && (c_IW'(i) >= w_sel)) ? w_snp[i+1] : w_snp[i];
            if (w_push && (w_wr_idx == c_CW'(i))) begin
                w_nxt[i] = w_incoming;
            end
        end

        w_count_nxt = r_count + {{(c_CW-1){1'b0}}, w_push}
                              - {{(c_CW-1){1'b0}}, w_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= w_nxt[i];
            end
            r_count <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_equeue_rs.sv
`default_nettype none
// ============================================================================
// Module   : tb_equeue_rs
// Brief    : Drives INT, DIV and LS instances with one shared stream and
//            compares each against a queue-based model of its issue rules.
// Revision : 1.0
// ============================================================================
module tb_equeue_rs;

    localparam int c_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dispatch_en;
    logic [5:0]  d_op, d_rd, d_rs, d_rt;
    logic [31:0] d_rsd, d_rtd;
    logic        d_rsv, d_rtv;
    logic [15:0] d_off;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_valid;
    logic        issue_done;

    logic        dut_dready [3];
    logic        dut_irdy   [3];
    logic [5:0]  dut_op     [3];
    logic [5:0]  dut_rd     [3];
    logic [5:0]  dut_rt     [3];
    logic [31:0] dut_rsd    [3];
    logic [31:0] dut_rtd    [3];
    logic [31:0] dut_addr   [3];
    logic [31:0] dut_data   [3];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        equeue_rs #(.KIND(g), .DEPTH(c_DEPTH)) u_dut (
            .clk              (clk),
            .rst_n            (rst_n),
            .dispatch_en      (dispatch_en),
            .dispatch_ready   (dut_dready[g]),
            .dispatch_opcode  (d_op),
            .dispatch_rdtag   (d_rd),
            .dispatch_rstag   (d_rs),
            .dispatch_rttag   (d_rt),
            .dispatch_rsdata  (d_rsd),
            .dispatch_rtdata  (d_rtd),
            .dispatch_rsvalid (d_rsv),
            .dispatch_rtvalid (d_rtv),
            .dispatch_offset  (d_off),
            .cdb_tag          (cdb_tag),
            .cdb_data         (cdb_data),
            .cdb_valid        (cdb_valid),
            .issue_ready      (dut_irdy[g]),
            .issue_opcode     (dut_op[g]),
            .issue_rdtag      (dut_rd[g]),
            .issue_rttag      (dut_rt[g]),
            .issue_rsdata     (dut_rsd[g]),
            .issue_rtdata     (dut_rtd[g]),
            .issue_addr       (dut_addr[g]),
            .issue_data       (dut_data[g]),
            .issue_done       (issue_done)
        );
    end

    typedef struct {
        logic [5:0]  op, rd, rs, rt;
        logic [31:0] rsd, rtd;
        bit          rsv, rtv;
        logic [15:0] off;
    } ment_t;

    // Index 0 of each queue is the oldest instruction held by that lane.
    ment_t mq [3][$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_ready(input int k, input ment_t e);
        if (k == 2 && e.op[0] == 1'b0) return e.rsv;
        return e.rsv && e.rtv;
    endfunction

    function automatic int m_sel(input int k);
        if (mq[k].size() == 0) return -1;
        if (k == 2) return m_ready(k, mq[k][0]) ? 0 : -1;
        for (int j = 0; j < mq[k].size(); j++) begin
            if (m_ready(k, mq[k][j])) return j;
        end
        return -1;
    endfunction

    function automatic ment_t m_snoop(input ment_t e);
        ment_t r = e;
        if (cdb_valid && !r.rsv && r.rs == cdb_tag) begin r.rsd = cdb_data; r.rsv = 1; end
        if (cdb_valid && !r.rtv && r.rt == cdb_tag) begin r.rtd = cdb_data; r.rtv = 1; end
        return r;
    endfunction

    task automatic check_outputs();
        for (int k = 0; k < 3; k++) begin
            int          s;
            ment_t       e;
            logic [31:0] x_addr, x_data;
            s = m_sel(k);
            check($sformatf("k%0d_dready", k), 32'(dut_dready[k]), 32'(mq[k].size() < c_DEPTH));
            check($sformatf("k%0d_irdy", k), 32'(dut_irdy[k]), 32'(s >= 0));
            if (s >= 0) begin
                e      = mq[k][s];
                x_addr = (k == 2) ? e.rsd + 32'($signed(e.off)) : 32'd0;
                x_data = (k == 2) ? e.rtd : 32'd0;
                check($sformatf("k%0d_op", k), 32'(dut_op[k]), 32'(e.op));
                check($sformatf("k%0d_rd", k), 32'(dut_rd[k]), 32'(e.rd));
                check($sformatf("k%0d_rt", k), 32'(dut_rt[k]), 32'(e.rt));
                check($sformatf("k%0d_rsd", k), dut_rsd[k], e.rsd);
                check($sformatf("k%0d_rtd", k), dut_rtd[k], e.rtd);
                check($sformatf("k%0d_addr", k), dut_addr[k], x_addr);
                check($sformatf("k%0d_data", k), dut_data[k], x_data);
            end else begin
                check($sformatf("k%0d_idle_bus", k),
                      32'(dut_op[k]) | 32'(dut_rd[k]) | 32'(dut_rt[k]) | dut_rsd[k]
                      | dut_rtd[k] | dut_addr[k] | dut_data[k], 32'd0);
            end
        end
    endtask

    task automatic model_step();
        ment_t ne;
        ne = '{op: d_op, rd: d_rd, rs: d_rs, rt: d_rt, rsd: d_rsd, rtd: d_rtd,
               rsv: d_rsv, rtv: d_rtv, off: d_off};
        for (int k = 0; k < 3; k++) begin
            int s;
            bit full;
            s    = m_sel(k);
            full = (mq[k].size() >= c_DEPTH);
            if (issue_done && s >= 0) mq[k].delete(s);
            for (int j = 0; j < mq[k].size(); j++) mq[k][j] = m_snoop(mq[k][j]);
            if (dispatch_en && !full) mq[k].push_back(m_snoop(ne));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
        dispatch_en = 0;
        issue_done  = 0;
        cdb_valid   = 0;
    endtask

    task automatic disp(input logic [5:0] op, input logic [5:0] rd, input logic [5:0] rs,
                        input logic [5:0] rt, input logic [31:0] rsd, input logic [31:0] rtd,
                        input logic rsv, input logic rtv, input logic [15:0] off);
        dispatch_en = 1;
        d_op = op; d_rd = rd; d_rs = rs; d_rt = rt;
        d_rsd = rsd; d_rtd = rtd; d_rsv = rsv; d_rtv = rtv; d_off = off;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_valid = 1; cdb_tag = tag; cdb_data = data;
    endtask

    // Asserted between edges so the asynchronous clear is observed directly.
    task automatic do_reset();
        rst_n = 0;
        #2;
        for (int k = 0; k < 3; k++) mq[k].delete();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_k%0d_dready", k), 32'(dut_dready[k]), 32'd1);
            check($sformatf("rst_k%0d_irdy", k), 32'(dut_irdy[k]), 32'd0);
        end
        check_outputs();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; dispatch_en = 0; issue_done = 0; cdb_valid = 0;
        d_op = 0; d_rd = 0; d_rs = 0; d_rt = 0; d_rsd = 0; d_rtd = 0;
        d_rsv = 0; d_rtv = 0; d_off = 0; cdb_tag = 0; cdb_data = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // INT basic issue
        disp(6'h20, 6'd1, 6'd2, 6'd3, 32'd2, 32'd2, 1, 1, 16'd0); tick();
        check("p2_irdy", 32'(dut_irdy[0]), 32'd1);
        check("p2_op", 32'(dut_op[0]), 32'h20);
        check("p2_rd", 32'(dut_rd[0]), 32'd1);
        check("p2_rsd", dut_rsd[0], 32'd2);
        check("p2_rtd", dut_rtd[0], 32'd2);
        issue_done = 1; tick();
        check("p2_after_pop", 32'(dut_irdy[0]), 32'd0);

        // Out-of-order issue around a waiting older entry
        do_reset();
        disp(6'h22, 6'd5, 6'd4, 6'd3, 32'd0, 32'd7, 0, 1, 16'd0); tick();
        disp(6'h20, 6'd6, 6'd1, 6'd2, 32'd3, 32'd4, 1, 1, 16'd0); tick();
        check("p3_b_first", 32'(dut_rd[0]), 32'd6);
        issue_done = 1; tick();
        check("p3_a_waits", 32'(dut_irdy[0]), 32'd0);
        cdb(6'd4, 32'h10); tick();
        check("p3_a_rd", 32'(dut_rd[0]), 32'd5);
        check("p3_a_rsd", dut_rsd[0], 32'h10);
        issue_done = 1; tick();

        // DIV full queue
        do_reset();
        disp(6'h0, 6'd9, 6'hE, 6'h7, 32'd100, 32'd7, 1, 1, 16'd0); tick();
        for (int j = 0; j < 3; j++) begin
            disp(6'h0, 6'(10 + j), 6'h30, 6'h31, 32'd0, 32'd0, 0, 0, 16'd0); tick();
        end
        check("p4_full", 32'(dut_dready[1]), 32'd0);
        disp(6'h0, 6'h3F, 6'h1, 6'h2, 32'd1, 32'd1, 1, 1, 16'd0); tick();
        check("p4_still_full", 32'(dut_dready[1]), 32'd0);
        check("p4_rd9", 32'(dut_rd[1]), 32'd9);
        issue_done = 1;
        disp(6'h0, 6'h3E, 6'h1, 6'h2, 32'd1, 32'd1, 1, 1, 16'd0);
        check("p4_full_pop", 32'(dut_dready[1]), 32'd0);
        tick();
        check("p4_reopen", 32'(dut_dready[1]), 32'd1);

        // LS address, data and in-order head
        do_reset();
        disp(6'h1, 6'd0, 6'd1, 6'd2, 32'h100, 32'hAB, 1, 1, 16'hFFFC); tick();
        check("p5_addr", dut_addr[2], 32'hFC);
        check("p5_data", dut_data[2], 32'hAB);
        issue_done = 1; tick();
        disp(6'h0, 6'd0, 6'hA, 6'h11, 32'd0, 32'd0, 0, 0, 16'd4); tick();
        disp(6'h0, 6'd0, 6'hB, 6'h12, 32'h300, 32'd0, 1, 0, 16'd8); tick();
        check("p5_head_blocks", 32'(dut_irdy[2]), 32'd0);
        cdb(6'hA, 32'h200); tick();
        check("p5_head_rdy", 32'(dut_irdy[2]), 32'd1);
        check("p5_head_addr", dut_addr[2], 32'h204);
        check("p5_head_rt", 32'(dut_rt[2]), 32'h11);
        issue_done = 1; tick();
        check("p5_next_addr", dut_addr[2], 32'h308);

        // Same-cycle dispatch and broadcast
        do_reset();
        disp(6'h20, 6'd3, 6'd6, 6'd7, 32'd0, 32'd5, 0, 1, 16'd0);
        cdb(6'd6, 32'hE); tick();
        check("p6_rdy", 32'(dut_irdy[0]), 32'd1);
        check("p6_rsd", dut_rsd[0], 32'hE);

        // Randomized traffic with occasional mid-operation reset
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) < 6)
                disp(6'($urandom), 6'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                     $urandom, $urandom, 1'($urandom), 1'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 1) cdb(6'($urandom_range(0, 7)), $urandom);
            issue_done = 1'($urandom_range(0, 2) != 0);
            tick();
            if ($urandom_range(0, 399) == 0) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
